// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point FFT front end.
// Q16.16 complex samples, frame size and framer state encoding.
package fft_pkg;

    localparam int FFT_N = 16;
    localparam int DW = 32;
    localparam int Q_FRAC = 16;
    localparam logic [DW-1:0] ONE_Q16 = 32'h0001_0000;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        FILL,
        FULL
    } state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex register file: one indexed write port,
// flat packed read of every entry (entry k at [DW*k +: DW]).
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  cplx_t           wdata,
    output logic [DW*N-1:0] rd_re,
    output logic [DW*N-1:0] rd_im
);

    cplx_t mem [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_rd
        assign rd_re[DW*k +: DW] = mem[k].re;
        assign rd_im[DW*k +: DW] = mem[k].im;
    end

endmodule

// File: rtl/fft16_input_framer.sv
// Streaming-to-parallel framer feeding the 16-point FFT core.
// One frame fills while the previous one is held on m_re/m_im.
module fft16_input_framer #(
    parameter int DW = 32,
    parameter int N  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    input  logic            s_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW*N-1:0] m_re,
    output logic [DW*N-1:0] m_im,
    output logic            err
);

    import fft_pkg::*;

    localparam int CW = $clog2(N);

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DW*N-1:0] rd_re, rd_im;
    logic acc, out_free, at_end, early;
    logic buf_we, ld_live, ld_buf, err_nx;
    cplx_t smp;

    assign s_ready  = (state == FILL);
    assign acc      = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;
    assign at_end   = (cnt == CW'(N-1));
    assign early    = s_last && !at_end;
    assign smp      = '{re: s_re, im: s_im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: if (acc && at_end && !out_free) state_nx = FULL;
            FULL: if (m_ready) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_comb begin
        buf_we  = 1'b0;
        ld_live = 1'b0;
        ld_buf  = 1'b0;
        err_nx  = 1'b0;
        unique case (state)
            FILL: begin
                if (acc) begin
                    err_nx  = early || (at_end && !s_last);
                    buf_we  = !early && (!at_end || !out_free);
                    ld_live = at_end && out_free;
                end
            end
            FULL: ld_buf = m_ready;
            default: ;
        endcase
    end

    // Early s_last drops the partial frame; a full count always restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (acc) begin
            cnt <= (early || at_end) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_re    <= '0;
            m_im    <= '0;
            err     <= 1'b0;
        end else begin
            err <= err_nx;
            if (ld_live) begin
                m_re    <= {s_re, rd_re[DW*(N-1)-1:0]};
                m_im    <= {s_im, rd_im[DW*(N-1)-1:0]};
                m_valid <= 1'b1;
            end else if (ld_buf) begin
                m_re    <= rd_re;
                m_im    <= rd_im;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    fft_frame_buf #(
        .N (N)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (cnt),
        .wdata (smp),
        .rd_re (rd_re),
        .rd_im (rd_im)
    );

endmodule

// File: tb/tb_fft16_input_framer.sv
// Bench for fft16_input_framer: frame-level model, scoreboard,
// directed scenarios and randomized handshake gaps.
module tb_fft16_input_framer;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int FW = DW * N;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic [DW-1:0] s_re = '0;
    logic [DW-1:0] s_im = '0;
    logic s_ready, m_valid, err;
    logic [FW-1:0] m_re, m_im;

    int checks = 0;
    int passed = 0;

    // model: output slot, one held complete frame, partial frame
    logic mv;
    logic merr;
    bit held;
    logic [FW-1:0] mo_re, mo_im, hd_re, hd_im;
    logic [31:0] pr[$];
    logic [31:0] pi[$];

    bit sb_on = 1'b0;
    int delivered = 0;
    logic [FW-1:0] sb_re[$];
    logic [FW-1:0] sb_im[$];

    fft16_input_framer #(.DW(DW), .N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_re    (s_re),
        .s_im    (s_im),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_re    (m_re),
        .m_im    (m_im),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [FW-1:0] pack_q(input logic [31:0] q[$]);
        logic [FW-1:0] v = '0;
        for (int k = 0; k < q.size(); k++) v[DW*k +: DW] = q[k];
        return v;
    endfunction

    function automatic logic [FW-1:0] pack_a(input logic [31:0] a[N]);
        logic [FW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[DW*k +: DW] = a[k];
        return v;
    endfunction

    task automatic model_reset();
        mv = 1'b0;
        merr = 1'b0;
        held = 1'b0;
        mo_re = '0;
        mo_im = '0;
        hd_re = '0;
        hd_im = '0;
        pr.delete();
        pi.delete();
    endtask

    task automatic model_update(input logic sv, input logic [31:0] re,
                                input logic [31:0] im, input logic last,
                                input logic mr);
        bit free;
        free = !mv || mr;
        merr = 1'b0;
        if (held) begin
            if (mr) begin
                mo_re = hd_re;
                mo_im = hd_im;
                mv = 1'b1;
                held = 1'b0;
            end
        end else begin
            if (mv && mr) mv = 1'b0;
            if (sv) begin
                if (last && pr.size() != N-1) begin
                    merr = 1'b1;
                    pr.delete();
                    pi.delete();
                end else begin
                    if (!last && pr.size() == N-1) merr = 1'b1;
                    pr.push_back(re);
                    pi.push_back(im);
                    if (pr.size() == N) begin
                        if (free) begin
                            mo_re = pack_q(pr);
                            mo_im = pack_q(pi);
                            mv = 1'b1;
                        end else begin
                            hd_re = pack_q(pr);
                            hd_im = pack_q(pi);
                            held = 1'b1;
                        end
                        pr.delete();
                        pi.delete();
                    end
                end
            end
        end
    endtask

    // Drive at negedge, clock the model at posedge, compare at negedge.
    task automatic step(input logic sv, input logic [31:0] re,
                        input logic [31:0] im, input logic last,
                        input logic mr);
        bit hold;
        logic [FW-1:0] pre_re, pre_im;
        s_valid = sv;
        s_re = re;
        s_im = im;
        s_last = last;
        m_ready = mr;
        #1;
        hold = m_valid && !mr;
        pre_re = m_re;
        pre_im = m_im;
        if (sb_on && m_valid && mr) begin
            if (sb_re.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                chk("sb_re", m_re, sb_re.pop_front());
                chk("sb_im", m_im, sb_im.pop_front());
                delivered++;
            end
        end
        @(posedge clk);
        model_update(sv, re, im, last, mr);
        @(negedge clk);
        chk("s_ready", s_ready, !held);
        chk("m_valid", m_valid, mv);
        chk("err", err, merr);
        chk("m_re", m_re, mo_re);
        chk("m_im", m_im, mo_im);
        if (hold) begin
            chk("stable_re", m_re, pre_re);
            chk("stable_im", m_im, pre_im);
        end
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 32'h0, 32'h0, 1'b0, mr);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_last = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_valid", m_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_re", m_re, 0);
        chk("rst_im", m_im, 0);
    endtask

    function automatic logic [31:0] pat(input int f, input int k);
        case (f)
            0: return (k < 4) ? ONE : 32'h0;
            1: return (k % 2 == 0) ? ONE : 32'h0;
            default: return (k == 1 || k == 2) ? ONE : 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] ar[N];
        logic [31:0] ai[N];
        logic [31:0] br[N];
        logic [FW-1:0] e;
        logic sv, mr, rdy;
        int f, k, cyc;

        #2;
        do_reset();

        // single frame: four +1.0 samples at the front
        for (int i = 0; i < N; i++) begin
            step(1'b1, pat(0, i), 32'h0, i == N-1, 1'b1);
            if (i == N-2) chk("t1_not_yet", m_valid, 0);
        end
        chk("t1_valid", m_valid, 1);
        chk("t1_re", m_re, {{(FW-128){1'b0}}, {4{ONE}}});
        chk("t1_im", m_im, 0);
        idle(1'b1);

        // three back-to-back frames
        for (int fr = 0; fr < 3; fr++) begin
            for (int i = 0; i < N; i++) begin
                step(1'b1, pat(fr, i), 32'h0, i == N-1, 1'b1);
                chk("t2_ready", s_ready, 1);
                chk("t2_pulse", m_valid, i == N-1);
            end
            e = '0;
            for (int i = 0; i < N; i++) e[DW*i +: DW] = pat(fr, i);
            chk("t2_frame", m_re, e);
        end
        idle(1'b1);

        // backpressure through two frames
        for (int i = 0; i < N; i++) begin
            ar[i] = 32'd100 + i;
            br[i] = 32'd300 + i;
        end
        for (int i = 0; i < N; i++) step(1'b1, ar[i], ~ar[i], i == N-1, 1'b0);
        for (int i = 0; i < N; i++) step(1'b1, br[i], ~br[i], i == N-1, 1'b0);
        chk("t3_ready_lo", s_ready, 0);
        chk("t3_hold_a", m_re, pack_a(ar));
        idle(1'b1);
        chk("t3_frame_b", m_re, pack_a(br));
        chk("t3_ready_hi", s_ready, 1);
        chk("t3_valid", m_valid, 1);
        idle(1'b1);
        chk("t3_drain", m_valid, 0);

        // early s_last on the 5th sample
        for (int i = 0; i < 5; i++) step(1'b1, i + 1, 32'h0, i == 4, 1'b1);
        chk("t4_err", err, 1);
        chk("t4_noframe", m_valid, 0);
        idle(1'b1);
        chk("t4_err_gone", err, 0);
        for (int i = 0; i < N; i++) step(1'b1, 6 + i, 32'h0, i == N-1, 1'b1);
        chk("t4_valid", m_valid, 1);
        chk("t4_slot0", m_re[31:0], 6);

        // async reset mid-frame with a frame pending
        for (int i = 0; i < 9; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", m_valid, 0);
        chk("t5_re", m_re, 0);
        chk("t5_im", m_im, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            ar[i] = $urandom;
            ai[i] = $urandom;
        end
        for (int i = 0; i < N; i++) step(1'b1, ar[i], ai[i], i == N-1, 1'b1);
        chk("t5_frame_re", m_re, pack_a(ar));
        chk("t5_frame_im", m_im, pack_a(ai));
        idle(1'b1);

        // random gaps on both sides, 100 frames through the scoreboard
        do_reset();
        sb_on = 1'b1;
        f = 0;
        k = 0;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            ar[i] = $urandom;
            ai[i] = $urandom;
        end
        while (delivered < 100 && cyc < 20000) begin
            sv = (f < 100) && ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) != 0);
            rdy = !held;
            if (sv) step(1'b1, ar[k], ai[k], k == N-1, mr);
            else step(1'b0, $urandom, $urandom, 1'b0, mr);
            if (sv && rdy) begin
                if (k == N-1) begin
                    sb_re.push_back(pack_a(ar));
                    sb_im.push_back(pack_a(ai));
                    f++;
                    k = 0;
                    for (int i = 0; i < N; i++) begin
                        ar[i] = $urandom;
                        ai[i] = $urandom;
                    end
                end else begin
                    k++;
                end
            end
            cyc++;
        end
        chk("t6_delivered", delivered, 100);
        chk("t6_sb_left", sb_re.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fft16_input_framer.md
Name: fft16_input_framer

Overview:
- Streaming-to-parallel framer that sits directly upstream of the 16-point pipelined FFT core (pplin_core).
- Accepts one complex Q16.16 sample per handshake and assembles a 16-sample frame.
- Presents the frame as the packed real and imaginary buses the core consumes, using a valid/ready handshake.
- One frame is filling while the previous frame is held stable, so a source can stream back-to-back with no bubbles.

Parameters:
- DW, 32, width of each real/imag sample (Q16.16; 32'h0001_0000 = +1.0)
- N, 16, samples per frame (power of two; counter width is log2(N))

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  framer can accept a sample
- s_re  in  DW  input sample, real part
- s_im  in  DW  input sample, imaginary part
- s_last  in  1  marks the final (N-1th) sample of a source frame
- m_valid  out  1  packed frame on m_re/m_im is valid
- m_ready  in  1  downstream consumes the frame
- m_re  out  DW*N  packed real frame; sample k at [DW*k +: DW], first-arrived sample in the LSBs
- m_im  out  DW*N  packed imaginary frame, same packing
- err  out  1  one-cycle pulse on a framing error

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: cnt=0, state=FILL, m_valid=0, err=0, m_re=0, m_im=0, fill buffer=0. s_ready=1 once out of reset.
- Accept rule: a sample is accepted at a rising edge when s_valid && s_ready.
- Output slot free: out_free = !m_valid || m_ready.
- State FILL (s_ready=1):
  - Accept with cnt<N-1: write fill[cnt] <= {s_re,s_im}; cnt++.
  - Accept with cnt==N-1 and out_free: load m_re/m_im from fill[0..N-2] plus the incoming sample in slot N-1; m_valid<=1; cnt<=0; stay in FILL.
  - Latency: m_valid rises on the edge that accepts sample N-1 (0 extra cycles).
  - Accept with cnt==N-1 and !out_free: fill[N-1] <= sample; go to FULL.
- State FULL (s_ready=0):
  - When m_ready (m_valid is 1 here): copy fill into m_re/m_im; m_valid stays 1; cnt<=0; go to FILL.
- m_valid falls when m_ready && no new frame loads on that edge.
- m_re/m_im change only on a frame load. They are stable while m_valid && !m_ready.
- Framing check, on accepted samples only:
  - s_last with cnt!=N-1: err pulse. The sample is discarded and the partial frame is dropped (cnt<=0, no output). The next sample starts a fresh frame.
  - No s_last at cnt==N-1: err pulse, but the frame completes normally (framer is count-driven).
- Simultaneous events: in FILL, consumption of the current output and completion of a new frame on the same edge reload the output, and m_valid stays 1.
- Reset mid-frame: the partial frame is lost, m_valid drops immediately, and the first post-reset sample is sample 0.
- Width: samples are stored verbatim. No arithmetic, sign extension or saturation.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=16, DW=32, Q_FRAC=16, ONE_Q16=32'h0001_0000
  - typedef cplx_t {re,im}
  - state enum {FILL,FULL}
- One natural sub-module, fft_frame_buf: an N-entry complex register file with indexed write and a flat packed read port. The framer FSM and counter stay in the top.

Test Plan:
- Reset, then stream 16 samples back-to-back with re=32'h0001_0000 for k<4 (else 0), im=0, s_last on k=15, m_ready=1:
  - m_valid rises on the 16th accept edge.
  - m_re[127:0]=4×32'h0001_0000; rest 0; err never asserted.
- Three back-to-back frames with m_ready=1:
  - s_ready is continuously 1.
  - m_valid pulses once per 16 cycles.
  - Frame 2 is (1,0,1,0,...) and frame 3 is (0,1,1,0,...) exactly in the packed slots.
- m_ready=0 through two complete input frames:
  - After the 2nd frame's 16th sample, s_ready=0 and m_re holds frame 1.
  - Raise m_ready for one cycle: m_re becomes frame 2, s_ready=1, m_valid stays 1.
- s_last asserted on the 5th sample:
  - err pulses one cycle and no frame is output.
  - The next 16 samples (s_last on 16th) produce one frame whose slot 0 holds the 6th sample.
- rst_n dropped asynchronously after 9 samples with a frame pending:
  - m_valid and m_re go 0 immediately.
  - After release, 16 samples produce a correct frame aligned from sample 0.
- Random s_valid/m_ready gaps over 100 frames:
  - The scoreboard shows every frame delivered in order, no duplication or loss.
  - m_re/m_im are stable whenever m_valid && !m_ready.
